// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice: the halt opcode,
// the PC value taken out of reset, the RUN/HALT state encoding and the
// saturating increment used by the optional fetch counter.
// Optional feature macro: FETCH_PERF_CNT_EN (fetch_cnt_o performance counter).
package fetch_pkg;

   localparam logic [7:0] OPC_HALT = 8'hE0;
   localparam logic [7:0] RESET_PC = 8'h00;
   localparam int         CNT_W    = 16;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   // Counter increment that sticks at all-ones instead of rolling over.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] result;
      result = value;
      if (value != {CNT_W{1'b1}}) begin
         result = value + 1'b1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction ROM bus between the fetch unit and the ROM.
// The ROM answers combinationally: rom_data_i is the word at rom_addr_o
// in the same cycle. The fetch side uses the master modport and the ROM
// (or the testbench standing in for it) uses the slave modport.
// Optional feature macro: FETCH_PERF_CNT_EN (not used in this file).
interface fetch_unit_if;

   logic [7:0] rom_addr_o;
   logic [7:0] rom_data_i;

   modport master (
      output rom_addr_o,
      input  rom_data_i
   );

   modport slave (
      input  rom_addr_o,
      output rom_data_i
   );

endinterface

// File: rtl/fetch_pc.sv
// Program counter for the fetch unit. It holds the address currently
// presented to the ROM, steps by one on each accepted fetch (wrapping
// 0xFF -> 0x00 through plain 8-bit overflow) and loads the branch target
// on a redirect. A redirect outranks the increment.
// Optional feature macro: FETCH_PERF_CNT_EN (not used in this file).
module fetch_pc
   import fetch_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       advance_i,
   input  logic       redirect_i,
   input  logic [7:0] redirect_addr_i,
   output logic [7:0] pc_o
);

   logic [7:0] pc_d;
   logic [7:0] pc_q;

   // Pick the next PC: redirect target first, then the sequential
   // successor, otherwise hold where we are.
   always_comb begin
      pc_d = pc_q;
      if (redirect_i) begin
         pc_d = redirect_addr_i;
      end else if (advance_i) begin
         pc_d = pc_q + 8'd1;
      end
   end

   // PC register; reset puts fetch back at the reset vector.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch stage. Each unstalled cycle it latches
// the ROM word at the current PC into inst_o/pc_o and moves the PC on.
// A downstream redirect replaces the PC and inserts one bubble; fetching
// the halt opcode parks the unit in HALT until the next reset.
// Optional feature macro: FETCH_PERF_CNT_EN adds the fetch_cnt_o counter.
module fetch_unit
   import fetch_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             stall_i,
   input  logic             redirect_i,
   input  logic [7:0]       redirect_addr_i,
   fetch_unit_if.master     rom_if,
   output logic [7:0]       inst_o,
   output logic [7:0]       pc_o,
   output logic             valid_o,
   output logic             halted_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] fetch_cnt_o
`endif
);

   fetch_state_e state_d;
   fetch_state_e state_q;

   logic [7:0] cur_pc;
   logic       fetch_go;
   logic       take_redirect;

   logic [7:0] inst_d;
   logic [7:0] inst_q;
   logic [7:0] pc_out_d;
   logic [7:0] pc_out_q;
   logic       valid_d;
   logic       valid_q;

   fetch_pc u_fetch_pc (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .advance_i       (fetch_go),
      .redirect_i      (take_redirect),
      .redirect_addr_i (redirect_addr_i),
      .pc_o            (cur_pc)
   );

   assign rom_if.rom_addr_o = cur_pc;

   // State register for the RUN/HALT machine.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // HALT is entered only when the halt opcode is actually accepted;
   // a redirect in the same cycle wins and keeps us running. There is
   // no way back out of HALT except reset.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (!redirect_i && !stall_i && (rom_if.rom_data_i == OPC_HALT)) begin
               state_d = HALT;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Work out what the fetch stage does this cycle. In RUN a redirect
   // beats a stall and drops valid for one bubble while keeping the old
   // instruction and PC on the outputs; an unstalled cycle loads the ROM
   // word. In HALT the PC is frozen, redirects are ignored and valid is
   // cleared as soon as decode takes the last instruction.
   always_comb begin
      fetch_go      = 1'b0;
      take_redirect = 1'b0;
      inst_d        = inst_q;
      pc_out_d      = pc_out_q;
      valid_d       = valid_q;
      unique case (state_q)
         RUN: begin
            if (redirect_i) begin
               take_redirect = 1'b1;
               valid_d       = 1'b0;
            end else if (!stall_i) begin
               fetch_go = 1'b1;
               inst_d   = rom_if.rom_data_i;
               pc_out_d = cur_pc;
               valid_d  = 1'b1;
            end
         end
         HALT: begin
            if (!stall_i) begin
               valid_d = 1'b0;
            end
         end
         default: begin
            valid_d = 1'b0;
         end
      endcase
   end

   // Output registers for the fetched instruction and its address.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inst_q   <= 8'h00;
         pc_out_q <= 8'h00;
         valid_q  <= 1'b0;
      end else begin
         inst_q   <= inst_d;
         pc_out_q <= pc_out_d;
         valid_q  <= valid_d;
      end
   end

   assign inst_o   = inst_q;
   assign pc_o     = pc_out_q;
   assign valid_o  = valid_q;
   assign halted_o = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
   logic [CNT_W-1:0] fetch_cnt_d;
   logic [CNT_W-1:0] fetch_cnt_q;

   // Count every newly loaded instruction, sticking at the top value.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      if (fetch_go) begin
         fetch_cnt_d = sat_inc(fetch_cnt_q);
      end
   end

   // Performance counter register, cleared by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios (straight-line
// fetch, stall, redirect, halt, wrap, reset, counter) followed by random
// stall/redirect/reset traffic over a random ROM, all compared against a
// cycle-level behavioural model of the fetch rules.
// Optional feature macro: FETCH_PERF_CNT_EN (counter checks enabled).
module tb_fetch_unit;
   import fetch_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [7:0]  redirect_addr_i = 8'h00;
   logic [7:0]  inst_o;
   logic [7:0]  pc_o;
   logic        valid_o;
   logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt_o;
`endif

   logic [7:0]  rom [256];

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int          m_pc;
   logic [7:0]  m_inst;
   logic [7:0]  m_pcout;
   logic        m_valid;
   logic        m_halted;
   int          m_cnt;

   fetch_unit_if rom_if ();

   assign rom_if.rom_data_i = rom[rom_if.rom_addr_o];

   fetch_unit dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .stall_i         (stall_i),
      .redirect_i      (redirect_i),
      .redirect_addr_i (redirect_addr_i),
      .rom_if          (rom_if.master),
      .inst_o          (inst_o),
      .pc_o            (pc_o),
      .valid_o         (valid_o),
      .halted_o        (halted_o)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt_o     (fetch_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, "_addr"},   {8'h00, rom_if.rom_addr_o}, 16'(m_pc));
      checkOutput({tag, "_inst"},   {8'h00, inst_o},            {8'h00, m_inst});
      checkOutput({tag, "_pc"},     {8'h00, pc_o},              {8'h00, m_pcout});
      checkOutput({tag, "_valid"},  {15'h0, valid_o},           {15'h0, m_valid});
      checkOutput({tag, "_halted"}, {15'h0, halted_o},          {15'h0, m_halted});
`ifdef FETCH_PERF_CNT_EN
      checkOutput({tag, "_cnt"},    fetch_cnt_o,                16'(m_cnt));
`endif
   endtask

   task automatic modelReset();
      m_pc     = 0;
      m_inst   = 8'h00;
      m_pcout  = 8'h00;
      m_valid  = 1'b0;
      m_halted = 1'b0;
      m_cnt    = 0;
   endtask

   // One clock of the fetch rules, evaluated on the pre-edge state.
   task automatic modelStep(input logic s, input logic r, input logic [7:0] a);
      if (m_halted) begin
         if (!s) m_valid = 1'b0;
      end else if (r) begin
         m_pc    = a;
         m_valid = 1'b0;
      end else if (!s) begin
         m_inst  = rom[m_pc];
         m_pcout = 8'(m_pc);
         m_valid = 1'b1;
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
         if (m_inst == 8'hE0) m_halted = 1'b1;
         m_pc = (m_pc + 1) % 256;
      end
   endtask

   task automatic applyStimulus(input string tag, input logic s, input logic r,
                                input logic [7:0] a);
      stall_i         = s;
      redirect_i      = r;
      redirect_addr_i = a;
      modelStep(s, r, a);
      @(posedge clk_i);
      #1;
      checkAll(tag);
   endtask

   // Assert reset off the clock edge, check it took effect at once,
   // then release it on the falling edge.
   task automatic doReset(input string tag);
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      rst_ni     = 1'b0;
      #1;
      modelReset();
      checkAll(tag);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 8'(i);
      rom[8'h60] = 8'hE0;
      modelReset();

      #3;
      doReset("rst0");

      // Straight-line fetch from 0x00
      applyStimulus("seq0", 1'b0, 1'b0, 8'h00);
      checkOutput("seq0_inst_const", {8'h00, inst_o}, 16'h0000);
      applyStimulus("seq1", 1'b0, 1'b0, 8'h00);
      checkOutput("seq1_inst_const", {8'h00, inst_o}, 16'h0001);
      applyStimulus("seq2", 1'b0, 1'b0, 8'h00);
      checkOutput("seq2_inst_const", {8'h00, inst_o}, 16'h0002);
      checkOutput("seq2_pc_const",   {8'h00, pc_o},   16'h0002);
      applyStimulus("seq3", 1'b0, 1'b0, 8'h00);
      applyStimulus("seq4", 1'b0, 1'b0, 8'h00);

      // Stall three cycles at PC 0x05
      for (int i = 0; i < 3; i++) begin
         applyStimulus("stall", 1'b1, 1'b0, 8'h00);
         checkOutput("stall_inst_const", {8'h00, inst_o}, 16'h0004);
         checkOutput("stall_addr_const", {8'h00, rom_if.rom_addr_o}, 16'h0005);
      end
      applyStimulus("resume", 1'b0, 1'b0, 8'h00);
      checkOutput("resume_inst_const", {8'h00, inst_o}, 16'h0005);

      // Redirect together with stall: redirect wins, one bubble
      applyStimulus("redir", 1'b1, 1'b1, 8'h16);
      checkOutput("redir_valid_const", {15'h0, valid_o}, 16'h0000);
      applyStimulus("redir_next", 1'b0, 1'b0, 8'h00);
      checkOutput("redir_pc_const", {8'h00, pc_o}, 16'h0016);

      // PC wrap 0xFF -> 0x00
      applyStimulus("wrap_jmp", 1'b0, 1'b1, 8'hFE);
      applyStimulus("wrap_fe",  1'b0, 1'b0, 8'h00);
      applyStimulus("wrap_ff",  1'b0, 1'b0, 8'h00);
      checkOutput("wrap_addr_const", {8'h00, rom_if.rom_addr_o}, 16'h0000);
      applyStimulus("wrap_00",  1'b0, 1'b0, 8'h00);

      // Reset mid-run, then the counter scenario
      doReset("rst_mid");
      checkOutput("rst_mid_inst_const", {8'h00, inst_o}, 16'h0000);
      for (int i = 0; i < 10; i++) applyStimulus("cnt_fetch", 1'b0, 1'b0, 8'h00);
      applyStimulus("cnt_bubble", 1'b0, 1'b1, 8'h5E);
`ifdef FETCH_PERF_CNT_EN
      checkOutput("cnt_const", fetch_cnt_o, 16'd10);
`endif

      // Halt at 0x60 (continues from the redirect to 0x5E)
      applyStimulus("halt_5e", 1'b0, 1'b0, 8'h00);
      applyStimulus("halt_5f", 1'b0, 1'b0, 8'h00);
      applyStimulus("halt_60", 1'b0, 1'b0, 8'h00);
      checkOutput("halt_inst_const",  {8'h00, inst_o},  16'h00E0);
      checkOutput("halt_valid_const", {15'h0, valid_o}, 16'h0001);
      applyStimulus("halted", 1'b0, 1'b0, 8'h00);
      checkOutput("halted_const",       {15'h0, halted_o}, 16'h0001);
      checkOutput("halted_valid_const", {15'h0, valid_o},  16'h0000);
      checkOutput("halted_addr_const",  {8'h00, rom_if.rom_addr_o}, 16'h0061);
      applyStimulus("halt_redir", 1'b0, 1'b1, 8'h10);
      checkOutput("halt_redir_addr_const", {8'h00, rom_if.rom_addr_o}, 16'h0061);
      applyStimulus("halt_hold", 1'b1, 1'b0, 8'h00);

      // Halt opcode on the bus coinciding with a redirect: stay in RUN
      doReset("rst_hr");
      applyStimulus("hr_jmp", 1'b0, 1'b1, 8'h5F);
      applyStimulus("hr_5f",  1'b0, 1'b0, 8'h00);
      applyStimulus("hr_both", 1'b0, 1'b1, 8'h20);
      checkOutput("hr_halted_const", {15'h0, halted_o}, 16'h0000);
      applyStimulus("hr_next", 1'b0, 1'b0, 8'h00);
      checkOutput("hr_pc_const", {8'h00, pc_o}, 16'h0020);

      // Random traffic over a random ROM
      for (int i = 0; i < 256; i++) begin
         rom[i] = ($urandom_range(0, 15) == 0) ? 8'hE0 : 8'($urandom);
      end
      doReset("rst_rnd");
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            doReset("rnd_rst");
         end else begin
            applyStimulus("rnd",
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 7) == 0),
                          8'($urandom));
         end
         if (m_halted && ($urandom_range(0, 4) == 0)) doReset("rnd_unhalt");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk_i, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-002 SHALL have port rst_ni, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-003 SHALL have port stall_i, input, 1 bit, meaning downstream decode is not ready and fetch holds.
REQ-004 SHALL have port redirect_i, input, 1 bit, meaning a taken beq0 or jmp was resolved downstream.
REQ-005 SHALL have port redirect_addr_i, input, 8 bits, the resolved branch target PC.
REQ-006 SHALL have port rom_addr_o, output, 8 bits, the address driven to the instruction ROM.
REQ-007 SHALL have port rom_data_i, input, 8 bits, the combinational ROM instruction for rom_addr_o.
REQ-008 SHALL have port inst_o, output, 8 bits, the registered fetched instruction.
REQ-009 SHALL have port pc_o, output, 8 bits, the address inst_o was fetched from.
REQ-010 SHALL have port valid_o, output, 1 bit, meaning inst_o/pc_o hold a live instruction.
REQ-011 SHALL have port halted_o, output, 1 bit, meaning fetch has stopped on a halt opcode.
REQ-012 SHALL have port fetch_cnt_o, output, 16 bits, the fetched-instruction count; present only with FETCH_PERF_CNT_EN.

Function
REQ-013 SHALL drive rom_addr_o combinationally from the internal PC register.
REQ-014 SHALL implement FSM states RUN and HALT; on reset, state is RUN.
REQ-015 SHALL, in RUN with stall_i=0 and redirect_i=0, latch inst_o<=rom_data_i, pc_o<=PC and valid_o<=1, and set PC<=PC+1 (1-cycle latency, address to inst_o).
REQ-016 SHALL wrap PC modulo 256 (0xFF -> 0x00) with no flag.
REQ-017 SHALL, in RUN with stall_i=1 and redirect_i=0, hold PC, inst_o, pc_o and valid_o unchanged.
REQ-018 SHALL give redirect_i priority over stall_i: PC<=redirect_addr_i and valid_o<=0 (one bubble); inst_o and pc_o hold.
REQ-019 SHALL, when the latched rom_data_i equals OPC_HALT (0xE0), present it with valid_o=1 and move to HALT in the same cycle.
REQ-020 SHALL, when halt fetch and redirect_i coincide, apply the redirect and stay in RUN.
REQ-021 SHALL, in HALT, assert halted_o, freeze PC, and drive valid_o<=0 once stall_i=0; redirect_i is ignored.
REQ-022 SHALL leave HALT only through reset.

Reset
REQ-023 SHALL, while rst_ni=0, asynchronously force PC=0x00, inst_o=0x00, pc_o=0x00, valid_o=0, halted_o=0, fetch_cnt_o=0 and state RUN.
REQ-024 SHALL, on reset asserted mid-operation, abandon any in-flight fetch and start fetching again at 0x00 after release.

Configuration
REQ-025 SHALL, with FETCH_PERF_CNT_EN defined, increment fetch_cnt_o on every cycle that loads valid_o<=1 with a new instruction, saturating at 0xFFFF.
REQ-026 SHALL, without FETCH_PERF_CNT_EN, omit the fetch_cnt_o port and its counter entirely.

Structure
REQ-027 SHALL take OPC_HALT, RESET_PC and the RUN/HALT state enum from shared package fetch_pkg.
REQ-028 SHALL place the PC register, increment, wrap and redirect mux in sub-module fetch_pc.

Verification
REQ-029 SHALL cover straight-line fetch: reset release with ROM word k = k -> inst_o = 0x00, 0x01, 0x02 on consecutive cycles, pc_o equal, valid_o=1.
REQ-030 SHALL cover stall: stall_i=1 for 3 cycles at PC=0x05 -> inst_o=0x04 and rom_addr_o=0x05 held, then 0x05 resumes.
REQ-031 SHALL cover redirect: redirect_i=1 with redirect_addr_i=0x16, together with stall_i=1 -> valid_o=0 for one cycle, next pc_o=0x16.
REQ-032 SHALL cover halt: ROM[0x60]=0xE0 -> inst_o=0xE0 with valid_o=1 for one cycle, then halted_o=1, valid_o=0, rom_addr_o=0x61 frozen, and a later redirect is ignored.
REQ-033 SHALL cover wrap and reset: PC=0xFF -> next rom_addr_o=0x00; rst_ni pulsed low mid-run -> all outputs 0 immediately.
REQ-034 SHALL cover the counter: with FETCH_PERF_CNT_EN, 10 unstalled fetches plus 1 redirect bubble -> fetch_cnt_o=10.
